// File: rtl/exmem_pkg.sv
// Shared types and constants for the EX/MEM pipeline register.
// The payload struct is sized by the default datapath widths used by exmem_skid_reg.
package exmem_pkg;
  localparam int XLEN_DEF  = 64;
  localparam int RD_W_DEF  = 5;
  localparam int CNT_W_DEF = 16;

  localparam int CTRL_W          = 6;
  localparam int CTRL_BRANCH     = 5;
  localparam int CTRL_MEM_READ   = 4;
  localparam int CTRL_MEM_TO_REG = 3;
  localparam int CTRL_MEM_WRITE  = 2;
  localparam int CTRL_REG_WRITE  = 1;
  localparam int CTRL_BR_TAKEN   = 0;

  typedef struct packed {
    logic [XLEN_DEF-1:0] add;
    logic [XLEN_DEF-1:0] alu;
    logic                zero;
    logic [XLEN_DEF-1:0] store;
    logic [RD_W_DEF-1:0] rd;
    logic [CTRL_W-1:0]   ctrl;
  } exmem_payload_t;

  localparam int PAYLOAD_W = $bits(exmem_payload_t);
endpackage

// File: rtl/exmem_skid_reg_skid_buffer.sv
// Generic 2-entry valid/ready skid buffer with flush; in_ready is a pure register output.
// The main entry drives the output; the skid entry absorbs the one beat accepted while stalling.
module skid_buffer #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);
  logic         main_vld_q, main_vld_d;
  logic         skid_vld_q, skid_vld_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         in_beat, out_beat;

  assign in_beat  = in_valid_i & ~skid_vld_q;
  assign out_beat = main_vld_q & out_ready_i;

  always_comb begin
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    main_d     = main_q;
    skid_d     = skid_q;
    if (!main_vld_q || out_beat) begin
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end else if (in_beat) begin
        main_d     = in_data_i;
        main_vld_d = 1'b1;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (in_beat) begin
      skid_d     = in_data_i;
      skid_vld_d = 1'b1;
    end
    // Flush only kills the valid bits; payload keeps its last value.
    if (flush_i) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
    end
  end

  assign in_ready_o  = ~skid_vld_q;
  assign out_valid_o = main_vld_q;
  assign out_data_o  = main_q;
endmodule

// File: rtl/exmem_skid_reg.sv
// EX/MEM pipeline register: skid-buffered payload, ctrl bubble gating and a saturating stall counter.
// Every field, branch_taken included, is captured from EX each beat.
module exmem_skid_reg
  import exmem_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int RD_W  = RD_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_add,
  input  logic [XLEN-1:0]   in_alu,
  input  logic              in_zero,
  input  logic [XLEN-1:0]   in_store,
  input  logic [RD_W-1:0]   in_rd,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_add,
  output logic [XLEN-1:0]   out_alu,
  output logic              out_zero,
  output logic [XLEN-1:0]   out_store,
  output logic [RD_W-1:0]   out_rd,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);
  exmem_payload_t   in_pl, out_pl;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    in_pl       = '0;
    in_pl.add   = in_add;
    in_pl.alu   = in_alu;
    in_pl.zero  = in_zero;
    in_pl.store = in_store;
    in_pl.rd    = in_rd;
    in_pl.ctrl  = in_ctrl;
  end

  skid_buffer #(
    .W(PAYLOAD_W)
  ) u_skid (
    .clk_i      (clk),
    .rst_ni     (reset),
    .flush_i    (flush),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_pl),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_pl)
  );

  assign out_add   = out_pl.add;
  assign out_alu   = out_pl.alu;
  assign out_zero  = out_pl.zero;
  assign out_store = out_pl.store;
  assign out_rd    = out_pl.rd;
  // Bubbles must never carry live control into MEM.
  assign out_ctrl  = out_valid ? out_pl.ctrl : '0;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_exmem_skid_reg.sv
// Directed bench for exmem_skid_reg: reset, streaming, back-pressure, flush, branch_taken, counter saturation.
module tb_exmem_skid_reg;
  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_zero, out_ready;
  logic [63:0] in_add, in_alu, in_store;
  logic [4:0]  in_rd;
  logic [5:0]  in_ctrl;

  logic        in_ready, out_valid, out_zero;
  logic [63:0] out_add, out_alu, out_store;
  logic [4:0]  out_rd;
  logic [5:0]  out_ctrl;
  logic [15:0] stall_cnt;

  logic        s_in_ready, s_out_valid, s_out_zero;
  logic [63:0] s_out_add, s_out_alu, s_out_store;
  logic [4:0]  s_out_rd;
  logic [5:0]  s_out_ctrl;
  logic [3:0]  s_stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  exmem_skid_reg dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_add(in_add), .in_alu(in_alu), .in_zero(in_zero), .in_store(in_store),
    .in_rd(in_rd), .in_ctrl(in_ctrl), .out_valid(out_valid), .out_ready(out_ready),
    .out_add(out_add), .out_alu(out_alu), .out_zero(out_zero), .out_store(out_store),
    .out_rd(out_rd), .out_ctrl(out_ctrl), .stall_cnt(stall_cnt)
  );

  exmem_skid_reg #(.CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_add(in_add), .in_alu(in_alu), .in_zero(in_zero), .in_store(in_store),
    .in_rd(in_rd), .in_ctrl(in_ctrl), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_add(s_out_add), .out_alu(s_out_alu), .out_zero(s_out_zero), .out_store(s_out_store),
    .out_rd(s_out_rd), .out_ctrl(s_out_ctrl), .stall_cnt(s_stall_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] alu, input logic [5:0] ctrl);
    in_valid = v;
    in_alu   = alu;
    in_add   = alu + 64'h1000;
    in_store = ~alu;
    in_zero  = (alu == 64'h0);
    in_rd    = alu[4:0];
    in_ctrl  = ctrl;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(1'b1, 64'h55, 6'h3f);

    // Reset held with a live EX beat
    repeat (3) tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
    chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    chk("rst_out_alu", out_alu, 64'd0);
    reset = 1'b1;
    drive(1'b0, 64'h0, 6'h0);
    tick();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_idle_valid", 64'(out_valid), 64'd0);

    // Streaming at full rate
    drive(1'b1, 64'h10, 6'b010010);
    tick();
    chk("str_alu0", out_alu, 64'h10);
    chk("str_add0", out_add, 64'h1010);
    chk("str_ctrl0", 64'(out_ctrl), 64'b010010);
    chk("str_rdy0", 64'(in_ready), 64'd1);
    drive(1'b1, 64'h20, 6'b010010);
    tick();
    chk("str_alu1", out_alu, 64'h20);
    chk("str_rdy1", 64'(in_ready), 64'd1);
    drive(1'b1, 64'h30, 6'b010010);
    tick();
    chk("str_alu2", out_alu, 64'h30);
    chk("str_store2", out_store, ~64'h30);
    chk("str_rd2", 64'(out_rd), 64'h10);
    chk("str_rdy2", 64'(in_ready), 64'd1);
    drive(1'b0, 64'h0, 6'h0);
    tick();
    chk("str_drain_valid", 64'(out_valid), 64'd0);
    chk("str_drain_ctrl", 64'(out_ctrl), 64'd0);
    chk("str_hold_alu", out_alu, 64'h30);

    // Back-pressure: A on output, B in skid, C held by EX
    out_ready = 1'b0;
    drive(1'b1, 64'hA, 6'b000110);
    tick();
    chk("bp_a_out", out_alu, 64'hA);
    drive(1'b1, 64'hB, 6'b000110);
    tick();
    chk("bp_rdy_full", 64'(in_ready), 64'd0);
    drive(1'b1, 64'hC, 6'b000110);
    repeat (3) tick();
    chk("bp_a_held", out_alu, 64'hA);
    chk("bp_valid", 64'(out_valid), 64'd1);
    chk("bp_rdy", 64'(in_ready), 64'd0);
    chk("bp_stall4", 64'(stall_cnt), 64'd4);
    out_ready = 1'b1;
    tick();
    chk("bp_b_out", out_alu, 64'hB);
    chk("bp_rdy_back", 64'(in_ready), 64'd1);
    tick();
    chk("bp_c_out", out_alu, 64'hC);
    chk("bp_c_valid", 64'(out_valid), 64'd1);
    drive(1'b0, 64'h0, 6'h0);
    tick();
    chk("bp_empty", 64'(out_valid), 64'd0);
    chk("bp_stall_kept", 64'(stall_cnt), 64'd4);

    // Flush with both entries full and a beat D offered
    out_ready = 1'b0;
    drive(1'b1, 64'h111, 6'h3f);
    tick();
    drive(1'b1, 64'h222, 6'h3f);
    tick();
    chk("fl_full_rdy", 64'(in_ready), 64'd0);
    chk("fl_full_ctrl", 64'(out_ctrl), 64'h3f);
    flush = 1'b1;
    drive(1'b1, 64'hD, 6'h3f);
    tick();
    flush = 1'b0;
    chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_ctrl", 64'(out_ctrl), 64'd0);
    chk("fl_rdy", 64'(in_ready), 64'd1);
    chk("fl_hold_alu", out_alu, 64'h111);
    out_ready = 1'b1;
    drive(1'b0, 64'h0, 6'h0);
    tick();
    chk("fl_no_d", 64'(out_valid), 64'd0);
    chk("fl_stall", 64'(stall_cnt), 64'd6);

    // Flush while empty must discard an accepted-looking beat
    flush = 1'b1;
    drive(1'b1, 64'h77, 6'h3f);
    tick();
    flush = 1'b0;
    drive(1'b0, 64'h0, 6'h0);
    chk("fl2_valid", 64'(out_valid), 64'd0);

    // branch_taken follows EX, not its own output
    drive(1'b1, 64'h40, 6'b000001);
    tick();
    chk("bt_one", 64'(out_ctrl), 64'b000001);
    drive(1'b1, 64'h50, 6'b100000);
    tick();
    chk("bt_zero", 64'(out_ctrl), 64'b100000);
    drive(1'b0, 64'h0, 6'h0);
    tick();

    // Reset mid-operation, then saturate the narrow counter
    out_ready = 1'b0;
    drive(1'b1, 64'h99, 6'h3);
    tick();
    reset = 1'b0;
    tick();
    chk("rst2_valid", 64'(out_valid), 64'd0);
    chk("rst2_stall", 64'(stall_cnt), 64'd0);
    chk("rst2_sat_stall", 64'(s_stall_cnt), 64'd0);
    reset = 1'b1;
    drive(1'b1, 64'h99, 6'h3);
    tick();
    drive(1'b0, 64'h0, 6'h0);
    repeat (15) tick();
    chk("sat_15", 64'(s_stall_cnt), 64'd15);
    repeat (5) tick();
    chk("sat_hold", 64'(s_stall_cnt), 64'd15);
    chk("sat_wide20", 64'(stall_cnt), 64'd20);
    chk("sat_out", s_out_alu, 64'h99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
